// File: rtl/jogo_pkg.sv
// Shared types and constants for the reaction-game match sequencer.
// States, LFSR seed/step and winner codes.
package jogo_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      WAIT,
      GO,
      RESULT,
      MATCH_END
   } state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   localparam logic [1:0] W_NONE = 2'b00;
   localparam logic [1:0] W_P1   = 2'b01;
   localparam logic [1:0] W_P2   = 2'b10;

   // Fibonacci, taps 16,14,13,11
   function automatic logic [15:0] lfsr_next(
      input logic [15:0] s
   );
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

endpackage

// File: rtl/controle_partida_lfsr16.sv
// Free-running 16-bit LFSR used for the random arm-to-GO delay.
// Advances every cycle outside reset.
module lfsr16
   import jogo_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   output logic [15:0] q
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         q <= LFSR_SEED;
      end else begin
         q <= lfsr_next(q);
      end
   end

endmodule

// File: rtl/controle_partida.sv
// Round/match sequencer for the two-player reaction game.
// Arms, waits a random delay, lights GO, judges presses, keeps score.
module controle_partida
   import jogo_pkg::*;
#(
   parameter int WIN_POINTS    = 8,
   parameter int DELAY_MIN     = 50_000_000,
   parameter int DELAY_BITS    = 26,
   parameter int GAP_CYCLES    = 100_000_000,
   parameter int REACT_TIMEOUT = 300_000_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       p1_btn,
   input  logic       p2_btn,
   output logic       go_led,
   output logic       p1vic,
   output logic       p2vic,
   output logic       score_clr,
   output logic [3:0] p1_score,
   output logic [3:0] p2_score,
   output logic [1:0] false_start,
   output logic       match_over,
   output logic [1:0] winner
);

   localparam int DW = (DELAY_BITS + 1 > 32) ? DELAY_BITS + 1 : 32;
   localparam int RB = (DELAY_BITS < 16) ? DELAY_BITS : 16;

   localparam logic [31:0] TMO_LD = 32'(REACT_TIMEOUT - 1);
   localparam logic [31:0] GAP_LD = 32'(GAP_CYCLES - 1);
   localparam logic [3:0]  WP     = 4'(WIN_POINTS);

   state_t        state;
   logic [15:0]   lfsr;
   logic [15:0]   rmask;
   logic [DW-1:0] dly;
   logic [DW-1:0] dly_load;
   logic [31:0]   tmo;
   logic [31:0]   gap;

   logic start_q;
   logic p1_q;
   logic p2_q;
   logic rise_s;
   logic rise_1;
   logic rise_2;

   logic       end_rnd;
   logic       hit1;
   logic       hit2;
   logic [1:0] fs_n;

   lfsr16 u_lfsr (
      .clock (clock),
      .reset (reset),
      .q     (lfsr)
   );

   assign rise_s = start & ~start_q;
   assign rise_1 = p1_btn & ~p1_q;
   assign rise_2 = p2_btn & ~p2_q;

   // Random bits above bit 15 do not exist and read as zero
   assign rmask    = 16'((32'd1 << RB) - 32'd1);
   assign dly_load = DW'(DELAY_MIN) + DW'(lfsr & rmask);

   always_comb begin
      end_rnd = 1'b0;
      hit1    = 1'b0;
      hit2    = 1'b0;
      fs_n    = false_start;
      if (state == WAIT) begin
         end_rnd = rise_1 | rise_2;
         hit1    = rise_2 & ~rise_1;
         hit2    = rise_1 & ~rise_2;
         fs_n    = {rise_2, rise_1};
      end else if (state == GO) begin
         end_rnd = rise_1 | rise_2 | (tmo == 32'd0);
         hit1    = rise_1 & ~rise_2;
         hit2    = rise_2 & ~rise_1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         start_q     <= 1'b0;
         p1_q        <= 1'b0;
         p2_q        <= 1'b0;
         dly         <= '0;
         tmo         <= '0;
         gap         <= '0;
         go_led      <= 1'b0;
         p1vic       <= 1'b0;
         p2vic       <= 1'b0;
         score_clr   <= 1'b0;
         p1_score    <= '0;
         p2_score    <= '0;
         false_start <= '0;
         match_over  <= 1'b0;
         winner      <= W_NONE;
      end else begin
         start_q   <= start;
         p1_q      <= p1_btn;
         p2_q      <= p2_btn;
         p1vic     <= 1'b0;
         p2vic     <= 1'b0;
         score_clr <= 1'b0;
         if (end_rnd) begin
            state       <= RESULT;
            gap         <= GAP_LD;
            go_led      <= 1'b0;
            false_start <= fs_n;
            if (hit1 && p1_score != WP) begin
               p1_score <= p1_score + 4'd1;
               p1vic    <= 1'b1;
            end
            if (hit2 && p2_score != WP) begin
               p2_score <= p2_score + 4'd1;
               p2vic    <= 1'b1;
            end
         end else begin
            unique case (state)
               IDLE, MATCH_END: begin
                  if (rise_s) begin
                     state       <= ARM;
                     score_clr   <= 1'b1;
                     p1_score    <= '0;
                     p2_score    <= '0;
                     false_start <= '0;
                     match_over  <= 1'b0;
                     winner      <= W_NONE;
                  end
               end
               ARM: begin
                  if (!p1_btn && !p2_btn) begin
                     dly   <= dly_load;
                     state <= WAIT;
                  end
               end
               WAIT: begin
                  if (dly == '0) begin
                     state  <= GO;
                     go_led <= 1'b1;
                     tmo    <= TMO_LD;
                  end else begin
                     dly <= dly - DW'(1);
                  end
               end
               GO: begin
                  tmo <= tmo - 32'd1;
               end
               RESULT: begin
                  if (gap != 32'd0) begin
                     gap <= gap - 32'd1;
                  end else if (p1_score == WP || p2_score == WP) begin
                     state      <= MATCH_END;
                     match_over <= 1'b1;
                     winner     <= (p1_score == WP) ? W_P1 :
                                   (p2_score == WP) ? W_P2 : W_NONE;
                  end else begin
                     false_start <= '0;
                     state       <= ARM;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_controle_partida.sv
// Scoreboard bench for controle_partida with small timing parameters.
// Stimulus queues expected events; a negedge monitor pops and compares.
module tb_controle_partida;

   localparam int WP  = 2;
   localparam int DMN = 4;
   localparam int DB  = 2;
   localparam int GAP = 3;
   localparam int RTO = 10;

   localparam logic [6:0] CLR = 7'h01;
   localparam logic [6:0] V1  = 7'h02;
   localparam logic [6:0] V2  = 7'h04;
   localparam logic [6:0] GR  = 7'h08;
   localparam logic [6:0] GF  = 7'h10;
   localparam logic [6:0] MR  = 7'h20;
   localparam logic [6:0] MF  = 7'h40;

   logic       clock  = 1'b0;
   logic       reset  = 1'b1;
   logic       start  = 1'b0;
   logic       p1_btn = 1'b0;
   logic       p2_btn = 1'b0;
   logic       go_led;
   logic       p1vic;
   logic       p2vic;
   logic       score_clr;
   logic [3:0] p1_score;
   logic [3:0] p2_score;
   logic [1:0] false_start;
   logic       match_over;
   logic [1:0] winner;

   controle_partida #(
      .WIN_POINTS    (WP),
      .DELAY_MIN     (DMN),
      .DELAY_BITS    (DB),
      .GAP_CYCLES    (GAP),
      .REACT_TIMEOUT (RTO)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .p1_btn      (p1_btn),
      .p2_btn      (p2_btn),
      .go_led      (go_led),
      .p1vic       (p1vic),
      .p2vic       (p2vic),
      .score_clr   (score_clr),
      .p1_score    (p1_score),
      .p2_score    (p2_score),
      .false_start (false_start),
      .match_over  (match_over),
      .winner      (winner)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [6:0] ev;
      logic [3:0] s1;
      logic [3:0] s2;
      logic [1:0] fs;
      logic [1:0] win;
      int         lo;
      int         hi;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   logic pgo = 1'b0;
   logic pmo = 1'b0;

   always @(negedge clock) begin
      logic [6:0] ev;
      exp_t       e;
      ev = {pmo & ~match_over, match_over & ~pmo,
            pgo & ~go_led, go_led & ~pgo,
            p2vic, p1vic, score_clr};
      pgo = go_led;
      pmo = match_over;
      if (ev != 7'h00) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event ev=%b cyc=%0d want none",
                     ev, cyc);
         end else begin
            e = q.pop_front();
            if (ev !== e.ev || p1_score !== e.s1 ||
                p2_score !== e.s2 || false_start !== e.fs ||
                winner !== e.win || cyc < e.lo || cyc > e.hi) begin
               errors++;
               $display("FAIL event got ev=%b s=%0d/%0d fs=%b w=%b cyc=%0d want ev=%b s=%0d/%0d fs=%b w=%b cyc=%0d..%0d",
                        ev, p1_score, p2_score, false_start, winner,
                        cyc, e.ev, e.s1, e.s2, e.fs, e.win, e.lo, e.hi);
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clock);
   endtask

   task automatic till(input int t);
      while (cyc < t) @(negedge clock);
   endtask

   task automatic push(input logic [6:0] ev, input int s1, input int s2,
                       input logic [1:0] fs, input logic [1:0] win,
                       input int lo, input int hi);
      exp_t e;
      e.ev  = ev;
      e.s1  = 4'(s1);
      e.s2  = 4'(s2);
      e.fs  = fs;
      e.win = win;
      e.lo  = lo;
      e.hi  = hi;
      q.push_back(e);
   endtask

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", n, act, exp);
      end
   endtask

   task automatic press(input logic a, input logic b);
      p1_btn = a;
      p2_btn = b;
      @(negedge clock);
      p1_btn = 1'b0;
      p2_btn = 1'b0;
   endtask

   task automatic wait_go(output int g);
      for (int k = 0; k < 40 && !go_led; k++) @(negedge clock);
      g = cyc;
      if (!go_led) begin
         checks++;
         errors++;
         $display("FAIL go_wait got go_led=0 want 1");
      end
   endtask

   task automatic all_zero(input string n);
      chk({n, "_go"}, go_led, 0);
      chk({n, "_vic"}, {p1vic, p2vic}, 0);
      chk({n, "_clr"}, score_clr, 0);
      chk({n, "_s1"}, p1_score, 0);
      chk({n, "_s2"}, p2_score, 0);
      chk({n, "_fs"}, false_start, 0);
      chk({n, "_mo"}, match_over, 0);
      chk({n, "_win"}, winner, 0);
   endtask

   initial begin
      int c, g, e, r, h;
      #2 reset = 1'b0;
      tick(3);
      all_zero("rst");
      reset = 1'b1;
      tick(2);

      // Match A, round 1: P1 reacts two cycles after GO
      c = cyc;
      push(CLR, 0, 0, 2'b00, 2'b00, c + 1, c + 1);
      push(GR, 0, 0, 2'b00, 2'b00, c + 7, c + 10);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_go(g);
      tick(2);
      e = g + 3;
      push(V1 | GF, 1, 0, 2'b00, 2'b00, e, e);
      press(1'b1, 1'b0);
      chk("go_off_result", go_led, 0);
      r = e;

      // Round 2: tie in GO
      push(GR, 1, 0, 2'b00, 2'b00, r + 9, r + 12);
      wait_go(g);
      e = g + 1;
      push(GF, 1, 0, 2'b00, 2'b00, e, e);
      press(1'b1, 1'b1);
      r = e;

      // Round 3: tie in WAIT
      till(r + 5);
      press(1'b1, 1'b1);
      chk("fs_tie_wait", false_start, 3);
      chk("s1_tie_wait", p1_score, 1);
      chk("s2_tie_wait", p2_score, 0);
      r = r + 6;

      // Round 4: no press, GO times out
      push(GR, 1, 0, 2'b00, 2'b00, r + 9, r + 12);
      wait_go(g);
      push(GF, 1, 0, 2'b00, 2'b00, g + RTO, g + RTO);
      r = g + RTO;
      till(r + 1);

      // Round 5: P2 wins in GO; start during RESULT is ignored
      push(GR, 1, 0, 2'b00, 2'b00, r + 9, r + 12);
      wait_go(g);
      tick();
      e = g + 2;
      push(V2 | GF, 1, 1, 2'b00, 2'b00, e, e);
      press(1'b0, 1'b1);
      start = 1'b1;
      tick();
      start = 1'b0;
      r = e;

      // Round 6: P1 jumps, P2 reaches WIN_POINTS
      till(r + 5);
      e = r + 6;
      push(V2, 1, 2, 2'b01, 2'b00, e, e);
      push(MR, 1, 2, 2'b01, 2'b10, e + GAP, e + GAP);
      press(1'b1, 1'b0);
      till(e + GAP + 1);
      chk("match_over", match_over, 1);
      chk("winner_p2", winner, 2);

      // Match B: start from MATCH_END
      c = cyc;
      push(CLR | MF, 0, 0, 2'b00, 2'b00, c + 1, c + 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      r = c + 1;
      till(r + 2);
      e = r + 3;
      push(V1, 1, 0, 2'b10, 2'b00, e, e);
      press(1'b0, 1'b1);
      chk("fs_p2_jump", false_start, 2);
      r = e;

      // Reset mid-WAIT with P1 held through release
      till(r + 6);
      p1_btn = 1'b1;
      reset  = 1'b0;
      #1;
      all_zero("midrst");
      tick(2);
      reset = 1'b1;
      tick(2);
      c = cyc;
      push(CLR, 0, 0, 2'b00, 2'b00, c + 1, c + 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(12);
      chk("arm_held_go", go_led, 0);
      h = cyc;
      p1_btn = 1'b0;
      push(GR, 0, 0, 2'b00, 2'b00, h + 6, h + 9);
      wait_go(g);
      e = g + 1;
      push(V2 | GF, 0, 1, 2'b00, 2'b00, e, e);
      press(1'b0, 1'b1);
      tick(6);
      chk("queue_empty", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
